btn_press_classifier: RTL and testbench

- Consumes the single-bit debounced, clock-synchronous level produced by the debouncer stage.
- Classifies each user action as a short press, a long press or a double press.
- Emits one-cycle event pulses and a wrapping press counter to the downstream control logic.
- Contains the edge detection, a 5-state FSM and a shared interval timer.

---
 rtl/btn_press_classifier.sv | 159 +++++++++++++++
 tb/tb_btn_press_classifier.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_press_classifier.sv
// btn_press_classifier
// Classifies presses of a debounced, clk-synchronous button level as short,
// long or double presses. Each class is reported as a one-cycle pulse. The
// block also keeps a wrapping count of rising edges on the button level.
// One interval timer is shared by the held-time and gap-time measurements.
`timescale 1ns/1ps

module btn_press_classifier #(
    parameter int unsigned TIMER_W     = 16,
    parameter int unsigned LONG_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES  = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       double_pulse,
    output logic [7:0] press_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HELD  = 3'd1,
        ST_LONG  = 3'd2,
        ST_GAP   = 3'd3,
        ST_HELD2 = 3'd4
    } state_t;

    // The thresholds are compared against the value the timer holds at the
    // deciding edge. The timer starts at 0 on the edge that enters the
    // state, so the limit is one less than the cycle count.
    localparam logic [TIMER_W-1:0] LONG_LIM = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LIM  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TMR_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TMR_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_in_q;
    logic [7:0]         r_press_cnt;
    logic               r_short;
    logic               r_long;
    logic               r_double;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               w_short_nxt;
    logic               w_long_nxt;
    logic               w_double_nxt;
    logic               w_rise;
    logic               w_fall;

    // Edge detection against the previous-cycle level of the button.
    always_comb begin
        w_rise = in & ~r_in_q;
        w_fall = ~in & r_in_q;
    end

    // Next-state, timer and pulse decisions for the press classifier FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_double_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HELD;
                    w_timer_nxt = TMR_ZERO;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = TMR_ZERO;
                end
            end
            ST_HELD: begin
                // A release on the threshold edge is still a short press.
                if (w_fall) begin
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = TMR_ZERO;
                end else if (in && (r_timer == LONG_LIM)) begin
                    w_state_nxt = ST_LONG;
                    w_timer_nxt = TMR_ZERO;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_HELD;
                    w_timer_nxt = r_timer + TMR_ONE;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_LONG;
                end
            end
            ST_GAP: begin
                // A second press on the timeout edge still counts as a double.
                if (w_rise) begin
                    w_state_nxt = ST_HELD2;
                    w_timer_nxt = TMR_ZERO;
                end else if (r_timer == GAP_LIM) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = TMR_ZERO;
                    w_short_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = r_timer + TMR_ONE;
                end
            end
            ST_HELD2: begin
                // The length of the second press is not timed.
                if (w_fall) begin
                    w_state_nxt  = ST_IDLE;
                    w_double_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_HELD2;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = TMR_ZERO;
            end
        endcase
    end

    // State, timer, edge-detect flop and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= TMR_ZERO;
            r_in_q      <= 1'b0;
            r_press_cnt <= 8'd0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
            r_double    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_in_q      <= in;
            r_press_cnt <= w_rise ? (r_press_cnt + 8'd1) : r_press_cnt;
            r_short     <= w_short_nxt;
            r_long      <= w_long_nxt;
            r_double    <= w_double_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign short_pulse  = r_short;
    assign long_pulse   = r_long;
    assign double_pulse = r_double;
    assign press_cnt    = r_press_cnt;
    assign busy         = r_busy;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Self-checking bench for btn_press_classifier (LONG_CYCLES=8, GAP_CYCLES=6).
// Button traces are built from level segments. The reference model derives
// the expected outputs for every edge from the lists of rise and fall edges.
`timescale 1ns/1ps

module tb_btn_press_classifier;

    localparam int LONG_C = 8;
    localparam int GAP_C  = 6;

    logic       clk;
    logic       rst;
    logic       in;
    logic       short_pulse;
    logic       long_pulse;
    logic       double_pulse;
    logic [7:0] press_cnt;
    logic       busy;

    int n_chk;
    int n_fail;

    bit   seq_q[$];
    logic obs_short[$];
    logic obs_long[$];
    logic obs_dbl[$];
    logic obs_busy[$];
    logic [7:0] obs_cnt[$];
    bit   e_short[$];
    bit   e_long[$];
    bit   e_dbl[$];
    bit   e_busy[$];
    int   e_cnt[$];

    btn_press_classifier #(
        .TIMER_W    (16),
        .LONG_CYCLES(LONG_C),
        .GAP_CYCLES (GAP_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .double_pulse(double_pulse),
        .press_cnt   (press_cnt),
        .busy        (busy)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_seg(input bit lvl, input int len);
        for (int i = 0; i < len; i++) seq_q.push_back(lvl);
    endtask

    function automatic int count_ones(input int which);
        int c;
        c = 0;
        for (int i = 0; i < obs_short.size(); i++) begin
            case (which)
                0:       c += (obs_short[i] === 1'b1) ? 1 : 0;
                1:       c += (obs_long[i]  === 1'b1) ? 1 : 0;
                default: c += (obs_dbl[i]   === 1'b1) ? 1 : 0;
            endcase
        end
        return c;
    endfunction

    // Reference model: expected outputs after each edge k, from press intervals.
    task automatic build_expect();
        int n, i, r, f, f2, big;
        int rq[$];
        int fq[$];
        bit prev;
        n = seq_q.size();
        big = n + 1000;
        e_short.delete(); e_long.delete(); e_dbl.delete(); e_busy.delete(); e_cnt.delete();
        prev = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (seq_q[k] && !prev) rq.push_back(k);
            if (!seq_q[k] && prev) fq.push_back(k);
            prev = seq_q[k];
            e_short.push_back(1'b0); e_long.push_back(1'b0); e_dbl.push_back(1'b0);
            e_busy.push_back(1'b0);
            e_cnt.push_back(rq.size() % 256);
        end
        i = 0;
        while (i < rq.size()) begin
            r = rq[i];
            f = (i < fq.size()) ? fq[i] : big;
            if (f - r > LONG_C) begin
                if (r + LONG_C < n) e_long[r + LONG_C] = 1'b1;
                for (int k = r; k < f && k < n; k++) e_busy[k] = 1'b1;
                i = i + 1;
            end else if ((i + 1 < rq.size()) && (rq[i+1] - f <= GAP_C)) begin
                f2 = (i + 1 < fq.size()) ? fq[i+1] : big;
                if (f2 < n) e_dbl[f2] = 1'b1;
                for (int k = r; k < f2 && k < n; k++) e_busy[k] = 1'b1;
                i = i + 2;
            end else begin
                if (f + GAP_C < n) e_short[f + GAP_C] = 1'b1;
                for (int k = r; k < f + GAP_C && k < n; k++) e_busy[k] = 1'b1;
                i = i + 1;
            end
        end
    endtask

    // Reset, replay seq_q one level per edge, then compare every edge.
    task automatic run_scn(input string name);
        obs_short.delete(); obs_long.delete(); obs_dbl.delete(); obs_busy.delete(); obs_cnt.delete();
        @(negedge clk);
        rst = 1'b0;
        in  = seq_q[0];
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < seq_q.size(); k++) begin
            in = seq_q[k];
            @(posedge clk);
            #1;
            obs_short.push_back(short_pulse);
            obs_long.push_back(long_pulse);
            obs_dbl.push_back(double_pulse);
            obs_busy.push_back(busy);
            obs_cnt.push_back(press_cnt);
            @(negedge clk);
        end
        build_expect();
        for (int k = 0; k < seq_q.size(); k++) begin
            check_val($sformatf("%s.short[%0d]", name, k), {31'd0, obs_short[k]}, {31'd0, e_short[k]});
            check_val($sformatf("%s.long[%0d]", name, k), {31'd0, obs_long[k]}, {31'd0, e_long[k]});
            check_val($sformatf("%s.double[%0d]", name, k), {31'd0, obs_dbl[k]}, {31'd0, e_dbl[k]});
            check_val($sformatf("%s.busy[%0d]", name, k), {31'd0, obs_busy[k]}, {31'd0, e_busy[k]});
            check_val($sformatf("%s.cnt[%0d]", name, k), {24'd0, obs_cnt[k]}, e_cnt[k]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".short"}, {31'd0, short_pulse}, 32'd0);
        check_val({tag, ".long"}, {31'd0, long_pulse}, 32'd0);
        check_val({tag, ".double"}, {31'd0, double_pulse}, 32'd0);
        check_val({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, ".cnt"}, {24'd0, press_cnt}, 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        in     = 1'b0;

        // Reset held with the input toggling: everything stays at zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in = ~in;
            #1;
            check_all_zero($sformatf("in_reset%0d", i));
        end
        @(negedge clk);
        in  = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_all_zero("after_release");

        // Short press: rise at 2, fall at 5, short after edge 11.
        seq_q.delete();
        add_seg(1'b0, 2); add_seg(1'b1, 3); add_seg(1'b0, 12);
        run_scn("short");
        check_val("short.at_f_plus_6", {31'd0, obs_short[11]}, 32'd1);
        check_val("short.n_short", count_ones(0), 32'd1);
        check_val("short.n_long", count_ones(1), 32'd0);
        check_val("short.n_double", count_ones(2), 32'd0);
        check_val("short.final_cnt", {24'd0, obs_cnt[16]}, 32'd1);
        check_val("short.final_busy", {31'd0, obs_busy[16]}, 32'd0);

        // Long press: rise at 1, long after edge 9, nothing else.
        seq_q.delete();
        add_seg(1'b0, 1); add_seg(1'b1, 20); add_seg(1'b0, 12);
        run_scn("long");
        check_val("long.at_e0_plus_8", {31'd0, obs_long[9]}, 32'd1);
        check_val("long.n_long", count_ones(1), 32'd1);
        check_val("long.n_short", count_ones(0), 32'd0);
        check_val("long.final_cnt", {24'd0, obs_cnt[32]}, 32'd1);

        // Fall on the threshold edge is short; one cycle later is long.
        seq_q.delete();
        add_seg(1'b1, 8); add_seg(1'b0, 12); add_seg(1'b1, 9); add_seg(1'b0, 12);
        run_scn("boundary");
        check_val("boundary.short_at_14", {31'd0, obs_short[14]}, 32'd1);
        check_val("boundary.long_at_28", {31'd0, obs_long[28]}, 32'd1);
        check_val("boundary.n_short", count_ones(0), 32'd1);
        check_val("boundary.n_long", count_ones(1), 32'd1);

        // Double press: second fall at edge 8.
        seq_q.delete();
        add_seg(1'b1, 3); add_seg(1'b0, 2); add_seg(1'b1, 3); add_seg(1'b0, 12);
        run_scn("double");
        check_val("double.at_8", {31'd0, obs_dbl[8]}, 32'd1);
        check_val("double.n_short", count_ones(0), 32'd0);
        check_val("double.final_cnt", {24'd0, obs_cnt[19]}, 32'd2);

        // Second rise on the timeout edge still wins: double at edge 12.
        seq_q.delete();
        add_seg(1'b1, 3); add_seg(1'b0, 6); add_seg(1'b1, 3); add_seg(1'b0, 12);
        run_scn("gap6");
        check_val("gap6.double_at_12", {31'd0, obs_dbl[12]}, 32'd1);
        check_val("gap6.n_short", count_ones(0), 32'd0);

        // One cycle longer gap: short at 9, then a fresh press from IDLE.
        seq_q.delete();
        add_seg(1'b1, 3); add_seg(1'b0, 7); add_seg(1'b1, 3); add_seg(1'b0, 12);
        run_scn("gap7");
        check_val("gap7.short_at_9", {31'd0, obs_short[9]}, 32'd1);
        check_val("gap7.busy_at_10", {31'd0, obs_busy[10]}, 32'd1);
        check_val("gap7.n_short", count_ones(0), 32'd2);
        check_val("gap7.n_double", count_ones(2), 32'd0);

        // Level already high at reset release: rise on the first edge.
        seq_q.delete();
        add_seg(1'b1, 4); add_seg(1'b0, 10);
        run_scn("high_at_release");
        check_val("high_at_release.cnt0", {24'd0, obs_cnt[0]}, 32'd1);

        // Randomized traces against the model.
        for (int t = 0; t < 20; t++) begin
            seq_q.delete();
            add_seg(1'b0, $urandom_range(0, 3));
            for (int j = 0; j < 8; j++) begin
                add_seg(1'b1, $urandom_range(1, 12));
                add_seg(1'b0, $urandom_range(1, 9));
            end
            add_seg(1'b0, 16);
            run_scn($sformatf("rand%0d", t));
        end

        // 256 short presses wrap the counter to zero.
        seq_q.delete();
        for (int j = 0; j < 256; j++) begin
            add_seg(1'b1, 2); add_seg(1'b0, 7);
        end
        add_seg(1'b0, 4);
        run_scn("wrap");
        check_val("wrap.final_cnt", {24'd0, obs_cnt[obs_cnt.size()-1]}, 32'd0);
        check_val("wrap.n_short", count_ones(0), 32'd256);

        // Reset while held: immediate clear, no pulse afterwards.
        @(negedge clk);
        rst = 1'b0;
        in  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in  = 1'b1;
        repeat (4) @(negedge clk);
        check_val("midrst.busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst.async");
        @(negedge clk);
        in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_all_zero($sformatf("midrst.after%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
